cpu0_mul_seq: RTL and testbench

CPU0_MUL_SEQ -- requirements
Module: cpu0_mul_seq

---
 rtl/cpu0_mul_seq.sv | 149 ++++++++++++++
 tb/tb_cpu0_mul_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu0_mul_seq.sv
// Sequencer that runs mul / mulx operations through a shared 32x32 multiply cell.
// mulx builds the 64-bit product from four 16x16 partial products plus a signed correction.
module cpu0_mul_seq #(
  parameter int CELL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [31:0] mul_cell_result,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_SS  = 2'd1;
  localparam logic [1:0] OP_SU  = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, CORR = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [31:0]   a_q, b_q;
  logic [1:0]    op_q;
  logic [63:0]   acc_q;
  logic [1:0]    issue_cnt_q;
  logic [CELL_LAT-1:0] vld_q;
  logic [CELL_LAT:0]   vld_next;
  logic [1:0]    cap_idx_q;
  logic [31:0]   pp_q;
  logic          pp_vld_q;
  logic [1:0]    pp_idx_q;
  logic [31:0]   result_q;
  logic          done_q;

  logic          accept, is_mulx, issuing, cell_vld, last_add;
  logic [5:0]    pp_sh;
  logic [63:0]   pp_shifted;
  logic [31:0]   sub_a, sub_b, corr_hi;

  // Handshake: start is taken on a rising edge only when busy is low (IDLE, which
  // includes the done cycle); once taken, busy stays high and start is ignored until
  // the edge that raises done for one cycle and drops busy together.
  assign accept   = (state_q == IDLE) && start;
  assign is_mulx  = (op_q != OP_MUL);
  assign issuing  = (state_q == ISSUE);
  assign vld_next = {vld_q, issuing};
  assign cell_vld = vld_q[CELL_LAT-1];
  assign last_add = pp_vld_q && (pp_idx_q == 2'd3);
  assign done     = done_q;
  assign result   = result_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: if (!is_mulx || issue_cnt_q == 2'd3) state_d = WAIT;
      WAIT:  if (is_mulx ? last_add : cell_vld) state_d = CORR;
      CORR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Cell operands are only non-zero while issuing; mulx walks the half-word pairs.
  always_comb begin
    busy     = (state_q != IDLE);
    mul_src1 = '0;
    mul_src2 = '0;
    if (state_q == ISSUE) begin
      if (!is_mulx) begin
        mul_src1 = a_q;
        mul_src2 = b_q;
      end else begin
        mul_src1 = {16'b0, issue_cnt_q[1] ? a_q[31:16] : a_q[15:0]};
        mul_src2 = {16'b0, issue_cnt_q[0] ? b_q[31:16] : b_q[15:0]};
      end
    end
  end

  always_comb begin
    case (pp_idx_q)
      2'd0:    pp_sh = 6'd0;
      2'd3:    pp_sh = 6'd32;
      default: pp_sh = 6'd16;
    endcase
    pp_shifted = {32'b0, pp_q} << pp_sh;
  end

  // The unsigned product over-counts by 2^32 * other operand for each negative signed input.
  always_comb begin
    sub_b   = (((op_q == OP_SS) || (op_q == OP_SU)) && a_q[31]) ? b_q : 32'd0;
    sub_a   = ((op_q == OP_SS) && b_q[31]) ? a_q : 32'd0;
    corr_hi = acc_q[63:32] - sub_b - sub_a;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_MUL;
      acc_q       <= '0;
      issue_cnt_q <= '0;
      vld_q       <= '0;
      cap_idx_q   <= '0;
      pp_q        <= '0;
      pp_vld_q    <= 1'b0;
      pp_idx_q    <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      vld_q  <= vld_next[CELL_LAT-1:0];
      done_q <= (state_q == CORR);
      if (accept) begin
        a_q         <= src1;
        b_q         <= src2;
        op_q        <= op;
        acc_q       <= '0;
        issue_cnt_q <= '0;
        cap_idx_q   <= '0;
        pp_vld_q    <= 1'b0;
      end else begin
        if (issuing) issue_cnt_q <= issue_cnt_q + 2'd1;
        pp_vld_q <= cell_vld && is_mulx;
        if (cell_vld && is_mulx) begin
          pp_q      <= mul_cell_result;
          pp_idx_q  <= cap_idx_q;
          cap_idx_q <= cap_idx_q + 2'd1;
        end
        // Partial products are registered first and accumulated one cycle later.
        if (cell_vld && !is_mulx)      acc_q <= {32'b0, mul_cell_result};
        else if (pp_vld_q)             acc_q <= acc_q + pp_shifted;
        else if (state_q == CORR)      acc_q[63:32] <= corr_hi;
        if (state_q == CORR) result_q <= is_mulx ? corr_hi : acc_q[31:0];
      end
    end
  end

endmodule

// File: tb/tb_cpu0_mul_seq.sv
// Bench for cpu0_mul_seq: two instances (CELL_LAT 1 and 2) share stimulus and are
// checked every cycle against an arithmetic reference model.
module tb_cpu0_mul_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src1 = '0, src2 = '0;

  logic        busy_w[2], done_w[2];
  logic [31:0] result_w[2], ms1_w[2], ms2_w[2], cell_w[2];
  logic [1:0]  dbg_w[2];

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset block
  always #5 clk = ~clk;

  cpu0_mul_seq #(.CELL_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .busy(busy_w[0]), .done(done_w[0]), .result(result_w[0]),
    .mul_src1(ms1_w[0]), .mul_src2(ms2_w[0]), .mul_cell_result(cell_w[0]),
    .state_dbg(dbg_w[0]));

  cpu0_mul_seq #(.CELL_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .busy(busy_w[1]), .done(done_w[1]), .result(result_w[1]),
    .mul_src1(ms1_w[1]), .mul_src2(ms2_w[1]), .mul_cell_result(cell_w[1]),
    .state_dbg(dbg_w[1]));

  // multiply cells: registered unsigned product, 1 and 2 stages
  logic [31:0] c1 = '0, c2a = '0, c2b = '0;
  always @(posedge clk) begin
    c1  <= ms1_w[0] * ms2_w[0];
    c2a <= ms1_w[1] * ms2_w[1];
    c2b <= c2a;
  end
  assign cell_w[0] = c1;
  assign cell_w[1] = c2b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference arithmetic
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (o)
      2'd0:    p = {32'b0, a} * {32'b0, b};
      2'd1:    p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      2'd2:    p = {{32{a[31]}}, a} * {32'b0, b};
      default: p = {32'b0, a} * {32'b0, b};
    endcase
    return (o == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic int lat_of(input int d, input logic [1:0] o);
    return ((o == 2'd0) ? 2 : 6) + d + 1;
  endfunction

  // cell operands expected k cycles after the accept edge
  function automatic logic [63:0] exp_src(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int k);
    if (o == 2'd0) return (k == 0) ? {a, b} : 64'd0;
    case (k)
      0: return {16'b0, a[15:0],  16'b0, b[15:0]};
      1: return {16'b0, a[15:0],  16'b0, b[31:16]};
      2: return {16'b0, a[31:16], 16'b0, b[15:0]};
      3: return {16'b0, a[31:16], 16'b0, b[31:16]};
      default: return 64'd0;
    endcase
  endfunction

  // scoreboard
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          cyc = 0;
  int          due[2] = '{-1, -1};
  int          acc_at[2] = '{0, 0};
  logic [1:0]  m_op[2];
  logic [31:0] m_a[2], m_b[2];
  logic [31:0] m_res[2] = '{32'd0, 32'd0};

  function automatic void push_exp(input int d, input logic [31:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [31:0] pop_exp(input int d);
    if (q_size(d) == 0) return 32'd0;
    return (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        due[d]   = -1;
        m_res[d] = 32'd0;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (start && cyc > due[d]) begin
          acc_at[d] = cyc;
          due[d]    = cyc + lat_of(d, op);
          m_op[d]   = op;
          m_a[d]    = src1;
          m_b[d]    = src2;
          push_exp(d, ref_mul(op, src1, src2));
        end
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        logic        eb, ed;
        logic [63:0] es;
        eb = (cyc < due[d]);
        ed = (cyc == due[d]);
        if (ed) begin
          check($sformatf("sb_entry%0d", d), q_size(d) != 0, 1);
          m_res[d] = pop_exp(d);
        end
        es = eb ? exp_src(m_op[d], m_a[d], m_b[d], cyc - acc_at[d]) : 64'd0;
        check($sformatf("busy%0d", d), busy_w[d], eb);
        check($sformatf("done%0d", d), done_w[d], ed);
        check($sformatf("result%0d", d), result_w[d], m_res[d]);
        check($sformatf("cell_ops%0d", d), {ms1_w[d], ms2_w[d]}, es);
      end
    end
  end

  // driver tasks: caller is at a negedge
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_l1, input int exp_l2);
    int l1, l2;
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk); #1 start = 1'b0;
    l1 = -1; l2 = -1;
    for (int t = 1; t <= 30 && (l1 < 0 || l2 < 0); t++) begin
      @(posedge clk); #1;
      if (done_w[0] && l1 < 0) l1 = t;
      if (done_w[1] && l2 < 0) l2 = t;
    end
    check("latency_lat1", l1, exp_l1);
    check("latency_lat2", l2, exp_l2);
    check("literal_res_lat1", result_w[0], exp_res);
    check("literal_res_lat2", result_w[1], exp_res);
  endtask

  logic [31:0] corner[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_FFFF};

  function automatic logic [31:0] rnd_val();
    if ($urandom_range(0, 1) == 1) return $urandom();
    return corner[$urandom_range(0, 5)];
  endfunction

  initial begin
    int  l1;
    bit  found;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_busy", busy_w[d], 0);
      check("reset_done", done_w[d], 0);
      check("reset_result", result_w[d], 0);
      check("reset_cell_ops", {ms1_w[d], ms2_w[d]}, 0);
    end
    @(negedge clk); reset = 1'b0;

    // directed literal expectations, first start on the first edge after release
    run_op(2'd0, 32'h0001_0003, 32'h0002_000F, 32'h0015_002D, 3, 4);
    @(negedge clk); run_op(2'd3, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, 7, 8);
    @(negedge clk); run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 7, 8);
    @(negedge clk); run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 7, 8);
    @(negedge clk); run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 7, 8);
    @(negedge clk); run_op(2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 7, 8);
    @(negedge clk); run_op(2'd2, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 7, 8);

    // start while busy is ignored
    @(negedge clk); start = 1'b1; op = 2'd3; src1 = 32'h0001_0003; src2 = 32'h0002_0005;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; op = 2'd1; src1 = 32'h8000_0000; src2 = 32'h8000_0000;
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);
    check("ignored_start_lat1", result_w[0], 32'h0000_0002);
    check("ignored_start_lat2", result_w[1], 32'h0000_0002);

    // back-to-back: start held in the done cycle
    start = 1'b1; op = 2'd3; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (done_w[0]) found = 1'b1;
    end
    check("b2b_first_done", found, 1);
    start = 1'b1; op = 2'd1; src1 = 32'h8000_0000; src2 = 32'h8000_0000;
    @(posedge clk); #1 start = 1'b0;
    l1 = -1;
    for (int t = 1; t <= 20 && l1 < 0; t++) begin
      @(posedge clk); #1;
      if (done_w[0]) l1 = t;
    end
    check("b2b_latency", l1, 7);
    check("b2b_result", result_w[0], 32'h4000_0000);
    check("b2b_other_held", result_w[1], 32'hFFFF_FFFE);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 2'($urandom_range(0, 3));
      src1  = rnd_val();
      src2  = rnd_val();
    end
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);

    // reset during WAIT aborts silently
    run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 7, 8);
    @(negedge clk); start = 1'b1; op = 2'd3; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("abort_busy", busy_w[d], 0);
      check("abort_result", result_w[d], 0);
      check("abort_done", done_w[d], 0);
      check("abort_cell_ops", {ms1_w[d], ms2_w[d]}, 0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_op(2'd0, 32'h0001_0003, 32'h0002_000F, 32'h0015_002D, 3, 4);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
